// File: rtl/button_event.sv
// button_event: turns a debounced button level into single-cycle press,
// long-press and release events, plus a sticky request flag with an
// acknowledge handshake and a saturating press counter.
//
// Optional auto-repeat while the button stays in the long-press state is
// built when the macro BUTTON_EVENT_REPEAT_EN is defined. Without it the
// long-press state only waits for release.

module button_event #(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned LONG_TIME   = 2000000,
  parameter int unsigned REPEAT_TIME = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sig_in,
  input  logic       req_ack,
  input  logic       cnt_clr,
  output logic       press_pulse,
  output logic       long_pulse,
  output logic       release_pulse,
  output logic       req,
  output logic [7:0] press_count,
  output logic       held
);

  // Terminal counter values; the counter is 24 bits so both timers fit.
  localparam logic [23:0] LONG_LAST   = 24'(LONG_TIME - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [23:0] REPEAT_LAST = 24'(REPEAT_TIME - 1);
`endif

  // Reject timer settings that cannot be represented by the 24-bit counter.
  if (LONG_TIME < 1 || LONG_TIME > 24'hFFFFFF) begin : g_badLong
    $error("button_event: LONG_TIME out of range 1..2^24-1");
  end
  if (REPEAT_TIME < 1 || REPEAT_TIME > 24'hFFFFFF) begin : g_badRepeat
    $error("button_event: REPEAT_TIME out of range 1..2^24-1");
  end

  // ARM waits for a release after reset so a button held through reset
  // (or the debounce stage still in reset) never produces a false press.
  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    PRESS = 2'd2,
    LONG  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [23:0] r_counter;
  logic [23:0] w_nextCounter;

  logic        r_pressPulse;
  logic        r_longPulse;
  logic        r_releasePulse;
  logic        r_req;
  logic [7:0]  r_pressCount;
  logic        r_held;

  logic        w_pressed;
  logic        w_nextPress;
  logic        w_nextLong;
  logic        w_nextRelease;
  logic        w_nextReq;
  logic [7:0]  w_nextCount;
  logic        w_nextHeld;

  // Normalise the button polarity so the rest of the logic sees "pressed".
  assign w_pressed = ACTIVE_LOW ? ~sig_in : sig_in;

  // Next-state, timer and event decode for the press/long/release FSM.
  always_comb begin
    w_nextState   = r_state;
    w_nextCounter = r_counter;
    w_nextPress   = 1'b0;
    w_nextLong    = 1'b0;
    w_nextRelease = 1'b0;

    case (r_state)
      ARM: begin
        if (!w_pressed) begin
          w_nextState   = IDLE;
          w_nextCounter = '0;
        end
      end

      IDLE: begin
        if (w_pressed) begin
          w_nextState   = PRESS;
          w_nextCounter = '0;
          w_nextPress   = 1'b1;
        end
      end

      PRESS: begin
        if (!w_pressed) begin
          w_nextState   = IDLE;
          w_nextCounter = '0;
          w_nextRelease = 1'b1;
        end else if (r_counter == LONG_LAST) begin
          w_nextState   = LONG;
          w_nextCounter = '0;
          w_nextLong    = 1'b1;
        end else begin
          w_nextCounter = r_counter + 24'd1;
        end
      end

      LONG: begin
        if (!w_pressed) begin
          w_nextState   = IDLE;
          w_nextCounter = '0;
          w_nextRelease = 1'b1;
        end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
          if (r_counter == REPEAT_LAST) begin
            w_nextCounter = '0;
            w_nextPress   = 1'b1;
          end else begin
            w_nextCounter = r_counter + 24'd1;
          end
`else
          w_nextCounter = '0;
`endif
        end
      end

      default: begin
        w_nextState   = ARM;
        w_nextCounter = '0;
      end
    endcase
  end

  // Request flag and press counter follow the press event being registered;
  // a new press always wins over an acknowledge or a clear.
  always_comb begin
    w_nextReq   = w_nextPress | (r_req & ~req_ack);
    w_nextCount = r_pressCount;
    if (cnt_clr) begin
      w_nextCount = {7'd0, w_nextPress};
    end else if (w_nextPress && (r_pressCount != 8'hFF)) begin
      w_nextCount = r_pressCount + 8'd1;
    end
    w_nextHeld = (w_nextState == PRESS) || (w_nextState == LONG);
  end

  // State, timer and all outputs are registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ARM;
      r_counter      <= '0;
      r_pressPulse   <= 1'b0;
      r_longPulse    <= 1'b0;
      r_releasePulse <= 1'b0;
      r_req          <= 1'b0;
      r_pressCount   <= '0;
      r_held         <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_counter      <= w_nextCounter;
      r_pressPulse   <= w_nextPress;
      r_longPulse    <= w_nextLong;
      r_releasePulse <= w_nextRelease;
      r_req          <= w_nextReq;
      r_pressCount   <= w_nextCount;
      r_held         <= w_nextHeld;
    end
  end

  assign press_pulse   = r_pressPulse;
  assign long_pulse    = r_longPulse;
  assign release_pulse = r_releasePulse;
  assign req           = r_req;
  assign press_count   = r_pressCount;
  assign held          = r_held;

endmodule

// File: tb/tb_button_event.sv
// Directed self-checking bench for button_event (ACTIVE_LOW=1, LONG_TIME=10,
// REPEAT_TIME=4). Expected values are hand-derived constants.

module tb_button_event;

  logic       clock = 1'b0;
  logic       resetN;
  logic       sigIn;
  logic       reqAck;
  logic       cntClr;
  logic       pressPulse;
  logic       longPulse;
  logic       releasePulse;
  logic       req;
  logic [7:0] pressCount;
  logic       held;

  int checks = 0;
  int errors = 0;

  int cycle = 0;
  int nPress = 0;
  int nLong = 0;
  int nRelease = 0;
  int nOverlap = 0;
  int lastPressCycle = 0;
  int lastLongCycle = 0;

  int p0, l0, r0, pStart, heldLow;

  button_event #(
    .ACTIVE_LOW (1'b1),
    .LONG_TIME  (10),
    .REPEAT_TIME(4)
  ) dut (
    .clk          (clock),
    .reset_n      (resetN),
    .sig_in       (sigIn),
    .req_ack      (reqAck),
    .cnt_clr      (cntClr),
    .press_pulse  (pressPulse),
    .long_pulse   (longPulse),
    .release_pulse(releasePulse),
    .req          (req),
    .press_count  (pressCount),
    .held         (held)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle number of the most recent rising edge.
  always @(posedge clock) cycle++;

  // Count events on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (pressPulse === 1'b1) begin
      nPress++;
      lastPressCycle = cycle;
    end
    if (longPulse === 1'b1) begin
      nLong++;
      lastLongCycle = cycle;
    end
    if (releasePulse === 1'b1) nRelease++;
    if (pressPulse === 1'b1 && longPulse === 1'b1) nOverlap++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic ack, input logic clr);
    sigIn  = s;
    reqAck = ack;
    cntClr = clr;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    resetN = 1'b0;
    sigIn  = 1'b0;
    reqAck = 1'b0;
    cntClr = 1'b0;
    repeat (3) tick();

    checkOutput("rst_press",   32'(pressPulse),   0);
    checkOutput("rst_long",    32'(longPulse),    0);
    checkOutput("rst_release", 32'(releasePulse), 0);
    checkOutput("rst_req",     32'(req),          0);
    checkOutput("rst_count",   32'(pressCount),   0);
    checkOutput("rst_held",    32'(held),         0);

    // Held "pressed" through and after reset: ARM must suppress events.
    resetN = 1'b1;
    p0 = nPress; r0 = nRelease;
    repeat (100) tick();
    checkOutput("arm_nopress",   32'(nPress - p0),   0);
    checkOutput("arm_norelease", 32'(nRelease - r0), 0);
    checkOutput("arm_held",      32'(held),          0);
    checkOutput("arm_req",       32'(req),           0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("idle_nopress", 32'(nPress - p0), 0);
    checkOutput("idle_count",   32'(pressCount),  0);

    // Short press then release.
    p0 = nPress; l0 = nLong; r0 = nRelease;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("short_pulse", 32'(pressPulse), 1);
    checkOutput("short_held",  32'(held),       1);
    checkOutput("short_req",   32'(req),        1);
    checkOutput("short_count", 32'(pressCount), 1);
    tick();
    checkOutput("short_pulse_end", 32'(pressPulse), 0);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("short_release", 32'(releasePulse), 1);
    checkOutput("short_unheld",  32'(held),         0);
    tick();
    checkOutput("short_release_end", 32'(releasePulse),  0);
    checkOutput("short_npress",      32'(nPress - p0),   1);
    checkOutput("short_nlong",       32'(nLong - l0),    0);
    checkOutput("short_nrelease",    32'(nRelease - r0), 1);

    // Long hold: long_pulse 10 cycles after press_pulse.
    p0 = nPress; l0 = nLong; r0 = nRelease;
    applyStimulus(1'b0, 1'b0, 1'b0);
    pStart = cycle;
    heldLow = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (held !== 1'b1) heldLow++;
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("long_release", 32'(releasePulse), 1);
    tick();
    checkOutput("long_delay",    32'(lastLongCycle - pStart), 10);
    checkOutput("long_nlong",    32'(nLong - l0),             1);
    checkOutput("long_heldlow",  32'(heldLow),                0);
    checkOutput("long_nrelease", 32'(nRelease - r0),          1);
`ifdef BUTTON_EVENT_REPEAT_EN
    checkOutput("rep_npress",   32'(nPress - p0),                    6);
    checkOutput("rep_lastgap",  32'(lastPressCycle - lastLongCycle), 20);
    checkOutput("rep_count",    32'(pressCount),                     7);
`else
    checkOutput("norep_npress", 32'(nPress - p0), 1);
    checkOutput("norep_count",  32'(pressCount),  2);
`endif

    // Request handshake: press wins over simultaneous ack.
    checkOutput("hs_req_before", 32'(req), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hs_press", 32'(pressPulse), 1);
    checkOutput("hs_setwins", 32'(req), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("hs_req_hold", 32'(req), 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("hs_ack_clear", 32'(req), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("hs_ack_idle", 32'(req), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Saturation over 260 back-to-back press/release pairs.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clr_count", 32'(pressCount), 0);
    cntClr = 1'b0;
    p0 = nPress;
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("sat_count",  32'(pressCount),  255);
    checkOutput("sat_npress", 32'(nPress - p0), 260);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr_press_count", 32'(pressCount), 1);
    checkOutput("clr_press_pulse", 32'(pressPulse), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();

    // Reset in the middle of a press, button still held afterwards.
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    resetN = 1'b0;
    #1;
    checkOutput("midrst_held",  32'(held),       0);
    checkOutput("midrst_count", 32'(pressCount), 0);
    checkOutput("midrst_req",   32'(req),        0);
    tick();
    resetN = 1'b1;
    p0 = nPress;
    repeat (5) tick();
    checkOutput("midrst_nopress", 32'(nPress - p0), 0);
    checkOutput("midrst_noheld",  32'(held),        0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midrst_repress", 32'(pressPulse), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();

    checkOutput("no_overlap", 32'(nOverlap), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
